// File: rtl/dmem_dump_ctrl.sv
// dmem_dump_ctrl: passes core memory traffic through, then after a halt and drain streams memory out over valid/ready.
// Optional feature macro SKIP_ZERO_EN: zero-valued words are read but never presented.
module dmem_dump_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int DRAIN_CYCLES = 10,
    parameter logic [ADDR_W-1:0] DUMP_BASE = '0,
    parameter logic [ADDR_W-1:0] DUMP_LAST = '1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       instr,
    input  logic              core_rd,
    input  logic              core_wr,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              halted,
    output logic              done
);
    localparam int CW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [2:0] {RUN, DRAIN, ISSUE, CAPTURE, PRESENT, DONE} state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [ADDR_W-1:0] ptr, ptr_n;
    logic              cap;
    logic              halt, pass, at_last;

    assign halt    = instr == 16'hE000 || instr == 16'hE7FF;
    assign pass    = state == RUN || state == DRAIN;
    assign at_last = ptr == DUMP_LAST;

    assign mem_rd     = pass ? core_rd : state == ISSUE;
    assign mem_wr     = pass & core_wr;
    assign mem_addr   = pass ? core_addr : ptr;
    assign mem_wdata  = pass ? core_wdata : '0;
    assign dump_valid = state == PRESENT;
    assign halted     = state != RUN;
    assign done       = state == DONE;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ptr_n   = ptr;
        cap     = 1'b0;
        case (state)
            RUN: begin
                cnt_n   = '0;
                state_n = halt ? DRAIN : RUN;
            end
            DRAIN: begin
                cnt_n   = cnt + CW'(1);
                state_n = cnt == CW'(DRAIN_CYCLES - 1) ? ISSUE : DRAIN;
            end
            ISSUE: state_n = CAPTURE;
            CAPTURE: begin
`ifdef SKIP_ZERO_EN
                if (mem_rdata == '0) begin
                    state_n = at_last ? DONE : ISSUE;
                    ptr_n   = at_last ? ptr : ptr + ADDR_W'(1);
                end else begin
                    cap     = 1'b1;
                    state_n = PRESENT;
                end
`else
                cap     = 1'b1;
                state_n = PRESENT;
`endif
            end
            PRESENT: begin
                // end test precedes the increment so DUMP_LAST at the top of the space never wraps
                if (dump_ready) begin
                    state_n = at_last ? DONE : ISSUE;
                    ptr_n   = at_last ? ptr : ptr + ADDR_W'(1);
                end
            end
            default: state_n = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            cnt       <= '0;
            ptr       <= DUMP_BASE;
            dump_addr <= '0;
            dump_data <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            ptr   <= ptr_n;
            if (cap) begin
                dump_addr <= ptr;
                dump_data <= mem_rdata;
            end
        end
    end
endmodule
